// File: rtl/csr_trap_unit_pkg.sv
// csr_trap_unit_pkg: opcodes, funct3 codes, CSR addresses, trap constants and FSM states
package csr_trap_unit_pkg;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_PRIV = 3'b000;
  localparam logic [2:0] F3_CSRRW = 3'b001;
  localparam logic [2:0] F3_CSRRS = 3'b010;
  localparam logic [2:0] F3_CSRRC = 3'b011;
  localparam logic [2:0] F3_ILLEGAL = 3'b100;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MISA = 12'h301;
  localparam logic [11:0] CSR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL = 12'h343;
  localparam logic [11:0] CSR_MCYCLE = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE = 12'hC00;
  localparam logic [11:0] CSR_INSTRET = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID = 12'hF12;
  localparam logic [11:0] CSR_MIMPID = 12'hF13;
  localparam logic [11:0] CSR_MHARTID = 12'hF14;
  localparam logic [31:0] MRET_INSTR = 32'h3020_0073;
  localparam int CAUSE_ILLEGAL = 2;
  typedef enum logic {IDLE, FLUSH} state_t;
endpackage

// File: rtl/csr_trap_unit_counter.sv
// csr_counter: up-counter with per-XLEN-half write ports; any half write freezes the increment
module csr_counter #(
  parameter int XLEN = 32,
  parameter int WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc,
  input  logic [WIDTH/XLEN-1:0]   wr,
  input  logic [XLEN-1:0]         wr_data,
  output logic [WIDTH-1:0]        value
);
  logic [WIDTH-1:0] nxt;
  always_comb begin
    nxt = |wr ? value : value + WIDTH'(inc);
    for (int i = 0; i < WIDTH / XLEN; i++) if (wr[i]) nxt[i*XLEN +: XLEN] = wr_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) value <= '0;
    else value <= nxt;
  end
endmodule

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: M-mode CSR file with Zicsr execution, trap entry, MRET and cycle/instret counters
module csr_trap_unit
  import csr_trap_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int COUNTER_WIDTH = 64,
  parameter int EX_WIDTH = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     PC,
  input  logic [31:0]         instr,
  input  logic                instr_valid,
  input  logic                exception_valid,
  input  logic [EX_WIDTH-1:0] exception,
  input  logic [XLEN-1:0]     exception_tval,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                retire,
  output logic [4:0]          rd_addr,
  output logic [XLEN-1:0]     rd_data,
  output logic                rd_enable,
  output logic                illegal_csr,
  output logic                flush,
  output logic [XLEN-1:0]     flush_addr
);
  localparam int CH = COUNTER_WIDTH / XLEN;
  localparam bit HAS_HI = COUNTER_WIDTH > XLEN;
  state_t state, state_nxt;
  logic mie, mpie;
  logic [XLEN-1:0] mtvec, mepc, mcause, mtval, mscratch, misa, old, src, wdata;
  logic [COUNTER_WIDTH-1:0] cyc, ret;
  logic [2*XLEN-1:0] cyc_x, ret_x;
  logic [2:0] f3;
  logic [11:0] addr;
  logic [4:0] zimm;
  logic csr_op, is_rw, is_rs, implemented, suppress, accepted, trap, mret, csr_write;
  assign f3 = instr[14:12];
  assign addr = instr[31:20];
  assign zimm = instr[19:15];
  assign rd_addr = instr[11:7];
  assign misa = {XLEN == 64 ? 2'b10 : 2'b01, {(XLEN - 28){1'b0}}, 26'h100};
  assign cyc_x = (2*XLEN)'(cyc);
  assign ret_x = (2*XLEN)'(ret);
  always_comb begin
    old = '0;
    implemented = 1'b1;
    case (addr)
      CSR_MISA: old = misa;
      CSR_MSTATUS: old = XLEN'({mpie, 3'b000, mie, 3'b000});
      CSR_MTVEC: old = mtvec;
      CSR_MEPC: old = mepc;
      CSR_MCAUSE: old = mcause;
      CSR_MTVAL: old = mtval;
      CSR_MSCRATCH: old = mscratch;
      CSR_MCYCLE, CSR_CYCLE: old = cyc_x[XLEN-1:0];
      CSR_MINSTRET, CSR_INSTRET: old = ret_x[XLEN-1:0];
      CSR_MCYCLEH, CSR_CYCLEH: begin
        old = cyc_x[2*XLEN-1:XLEN];
        implemented = HAS_HI;
      end
      CSR_MINSTRETH, CSR_INSTRETH: begin
        old = ret_x[2*XLEN-1:XLEN];
        implemented = HAS_HI;
      end
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID: old = '0;
      default: implemented = 1'b0;
    endcase
  end
  assign csr_op = instr[6:0] == OP_SYSTEM && f3 != F3_PRIV;
  assign is_rw = f3 == F3_CSRRW || f3 == F3_CSRRWI;
  assign is_rs = f3 == F3_CSRRS || f3 == F3_CSRRSI;
  assign src = f3[2] ? XLEN'(zimm) : wr_data;
  assign suppress = !is_rw && zimm == 5'd0;
  assign wdata = is_rw ? src : is_rs ? old | src : old & ~src;
  assign illegal_csr = instr_valid && csr_op &&
                       (!implemented || (addr[11:10] == 2'b11 && !suppress) || f3 == F3_ILLEGAL);
  assign accepted = instr_valid && state == IDLE;
  assign trap = accepted && (exception_valid || illegal_csr);
  assign mret = accepted && !exception_valid && instr == MRET_INSTR;
  assign csr_write = accepted && csr_op && !exception_valid && !illegal_csr && !suppress;
  assign rd_enable = accepted && csr_op && !exception_valid && !illegal_csr && rd_addr != 5'd0;
  assign rd_data = instr_valid && csr_op ? old : '0;
  assign flush = state == FLUSH;
  always_comb state_nxt = trap || mret ? FLUSH : IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      flush_addr <= '0;
    end else begin
      state <= state_nxt;
      flush_addr <= trap ? mtvec : mret ? mepc : '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mie <= 1'b0;
      mpie <= 1'b0;
      mtvec <= RESET_VECTOR & ~XLEN'(3);
      mepc <= '0;
      mcause <= '0;
      mtval <= '0;
      mscratch <= '0;
    end else if (trap) begin
      mepc <= PC & ~XLEN'(3);
      mcause <= exception_valid ? XLEN'(exception) : XLEN'(CAUSE_ILLEGAL);
      mtval <= exception_valid ? exception_tval : XLEN'(instr);
      mpie <= mie;
      mie <= 1'b0;
    end else if (mret) begin
      mie <= mpie;
      mpie <= 1'b1;
    end else if (csr_write) begin
      case (addr)
        CSR_MSTATUS: begin
          mie <= wdata[3];
          mpie <= wdata[7];
        end
        CSR_MTVEC: mtvec <= wdata & ~XLEN'(3);
        CSR_MEPC: mepc <= wdata & ~XLEN'(3);
        CSR_MCAUSE: mcause <= wdata;
        CSR_MTVAL: mtval <= wdata;
        CSR_MSCRATCH: mscratch <= wdata;
        default: ;
      endcase
    end
  end
  csr_counter #(.XLEN(XLEN), .WIDTH(COUNTER_WIDTH)) u_mcycle (
    .clk(clk),
    .rst(rst),
    .inc(1'b1),
    .wr(CH'({csr_write && addr == CSR_MCYCLEH, csr_write && addr == CSR_MCYCLE})),
    .wr_data(wdata),
    .value(cyc)
  );
  csr_counter #(.XLEN(XLEN), .WIDTH(COUNTER_WIDTH)) u_minstret (
    .clk(clk),
    .rst(rst),
    .inc(retire),
    .wr(CH'({csr_write && addr == CSR_MINSTRETH, csr_write && addr == CSR_MINSTRET})),
    .wr_data(wdata),
    .value(ret)
  );
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed plus randomized checks of csr_trap_unit against a behavioural model
module tb_csr_trap_unit;
  localparam logic [31:0] RV = 32'h0000_0080;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] MRET = 32'h3020_0073;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] pc, instr, exception_tval, wr_data, rd_data, flush_addr;
  logic instr_valid, exception_valid, retire, rd_enable, illegal_csr, flush;
  logic [3:0] exception;
  logic [4:0] rd_addr;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct packed {
    logic mie, mpie, busy;
    logic [31:0] mtvec, mepc, mcause, mtval, mscratch, faddr;
    logic [63:0] cyc, ret;
  } model_t;
  model_t m, n;
  logic [11:0] addrs [20] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                              12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80,
                              12'hC82, 12'hF11, 12'hF14, 12'h123, 12'h7C0, 12'hF15};
  csr_trap_unit #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .rst(rst), .PC(pc), .instr(instr), .instr_valid(instr_valid),
    .exception_valid(exception_valid), .exception(exception), .exception_tval(exception_tval),
    .wr_data(wr_data), .retire(retire), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_enable(rd_enable), .illegal_csr(illegal_csr), .flush(flush), .flush_addr(flush_addr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] csr_i(input logic [11:0] a, input logic [4:0] rs,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {a, rs, f3, rd, 7'h73};
  endfunction
  function automatic logic [32:0] ref_read(input logic [11:0] a);
    case (a)
      12'h301: return {1'b1, 32'h4000_0100};
      12'h300: return {1'b1, 24'h0, m.mpie, 3'b000, m.mie, 3'b000};
      12'h305: return {1'b1, m.mtvec};
      12'h340: return {1'b1, m.mscratch};
      12'h341: return {1'b1, m.mepc};
      12'h342: return {1'b1, m.mcause};
      12'h343: return {1'b1, m.mtval};
      12'hB00, 12'hC00: return {1'b1, m.cyc[31:0]};
      12'hB80, 12'hC80: return {1'b1, m.cyc[63:32]};
      12'hB02, 12'hC02: return {1'b1, m.ret[31:0]};
      12'hB82, 12'hC82: return {1'b1, m.ret[63:32]};
      12'hF11, 12'hF12, 12'hF13, 12'hF14: return {1'b1, 32'h0};
      default: return 33'h0;
    endcase
  endfunction
  task automatic model_check();
    logic [2:0] f3;
    logic [32:0] r;
    logic op, sup, ill, acc, trap, mret, wr;
    logic [31:0] src, nv;
    f3 = instr[14:12];
    op = instr[6:0] == 7'h73 && f3 != 3'b000;
    r = ref_read(instr[31:20]);
    sup = f3 inside {3'b010, 3'b011, 3'b110, 3'b111} && instr[19:15] == 5'd0;
    ill = instr_valid && op && (!r[32] || (instr[31:30] == 2'b11 && !sup) || f3 == 3'b100);
    acc = instr_valid && !m.busy;
    trap = acc && (exception_valid || ill);
    mret = acc && !exception_valid && instr == MRET;
    wr = acc && op && !exception_valid && !ill && !sup;
    check("flush", flush, m.busy);
    check("flush_addr", flush_addr, m.faddr);
    check("rd_addr", rd_addr, instr[11:7]);
    if (!m.busy) check("illegal_csr", illegal_csr, ill);
    check("rd_enable", rd_enable, acc && op && !exception_valid && !ill && instr[11:7] != 5'd0);
    if (instr_valid && op && !ill) check("rd_data", rd_data, r[31:0]);
    else if (!(instr_valid && op)) check("rd_data_idle", rd_data, 0);
    src = f3[2] ? {27'd0, instr[19:15]} : wr_data;
    nv = f3[1:0] == 2'b01 ? src : f3[1:0] == 2'b10 ? (r[31:0] | src) : (r[31:0] & ~src);
    n = m;
    n.busy = trap || mret;
    n.faddr = trap ? m.mtvec : mret ? m.mepc : 32'h0;
    n.cyc = m.cyc + 64'd1;
    n.ret = m.ret + {63'd0, retire};
    if (trap) begin
      n.mepc = pc & ~32'd3;
      n.mcause = exception_valid ? {28'd0, exception} : 32'd2;
      n.mtval = exception_valid ? exception_tval : instr;
      n.mpie = m.mie;
      n.mie = 1'b0;
    end else if (mret) begin
      n.mie = m.mpie;
      n.mpie = 1'b1;
    end else if (wr) begin
      case (instr[31:20])
        12'h300: begin
          n.mie = nv[3];
          n.mpie = nv[7];
        end
        12'h305: n.mtvec = nv & ~32'd3;
        12'h340: n.mscratch = nv;
        12'h341: n.mepc = nv & ~32'd3;
        12'h342: n.mcause = nv;
        12'h343: n.mtval = nv;
        12'hB00: n.cyc = {m.cyc[63:32], nv};
        12'hB80: n.cyc = {nv, m.cyc[31:0]};
        12'hB02: n.ret = {m.ret[63:32], nv};
        12'hB82: n.ret = {nv, m.ret[31:0]};
        default: ;
      endcase
    end
  endtask
  task automatic issue(input logic [31:0] i, input logic [31:0] wd = 0, input logic exv = 0,
                       input logic [3:0] ex = 0, input logic [31:0] tv = 0,
                       input logic [31:0] p = 0, input logic rt = 0, input logic v = 1);
    instr = i;
    wr_data = wd;
    exception_valid = exv;
    exception = ex;
    exception_tval = tv;
    pc = p;
    retire = rt;
    instr_valid = v;
    #1 model_check();
  endtask
  task automatic tick();
    @(posedge clk);
    m = n;
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    instr = NOP;
    instr_valid = 1'b0;
    exception_valid = 1'b0;
    exception = '0;
    exception_tval = '0;
    wr_data = '0;
    pc = '0;
    retire = 1'b0;
    #1;
    m = '0;
    m.mtvec = RV;
    check("rst_flush", flush, 0);
    check("rst_flush_addr", flush_addr, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    logic [31:0] ill_i;
    logic [31:0] ins;
    logic [11:0] a;
    @(negedge clk);
    do_reset();
    issue(csr_i(12'hB00, 5'd0, 3'b010, 5'd3));
    check("mcycle_after_reset", rd_data, 0);
    tick();
    issue(csr_i(12'h305, 5'd1, 3'b001, 5'd1), 32'h100);
    check("mtvec_reset_val", rd_data, RV);
    check("rd_enable_rw", rd_enable, 1);
    tick();
    issue(csr_i(12'h305, 5'd0, 3'b010, 5'd2), 32'hF0);
    check("mtvec_written", rd_data, 32'h100);
    tick();
    issue(csr_i(12'h305, 5'd0, 3'b010, 5'd2));
    check("rs_x0_no_write", rd_data, 32'h100);
    tick();
    issue(csr_i(12'h300, 5'd8, 3'b110, 5'd0));
    tick();
    issue(csr_i(12'h300, 5'd0, 3'b010, 5'd1));
    check("mstatus_mie", rd_data, 32'h8);
    tick();
    issue(NOP, 0, 1, 4'd5, 32'hDEAD, 32'h2C);
    check("exc_rd_enable", rd_enable, 0);
    tick();
    check("trap_flush", flush, 1);
    check("trap_flush_addr", flush_addr, 32'h100);
    issue(NOP, 0, 1, 4'd7, 32'hBEEF, 32'h50);
    tick();
    issue(csr_i(12'h341, 5'd0, 3'b010, 5'd1));
    check("no_second_flush", flush, 0);
    check("mepc", rd_data, 32'h2C);
    tick();
    issue(csr_i(12'h342, 5'd0, 3'b010, 5'd1));
    check("mcause", rd_data, 32'h5);
    tick();
    issue(csr_i(12'h343, 5'd0, 3'b010, 5'd1));
    check("mtval", rd_data, 32'hDEAD);
    tick();
    issue(csr_i(12'h300, 5'd0, 3'b010, 5'd1));
    check("mstatus_trap", rd_data, 32'h80);
    tick();
    issue(MRET, 0, 0, 0, 0, 32'h60);
    tick();
    check("mret_flush", flush, 1);
    check("mret_flush_addr", flush_addr, 32'h2C);
    issue(NOP);
    tick();
    issue(csr_i(12'h300, 5'd0, 3'b010, 5'd1));
    check("mstatus_mret", rd_data, 32'h88);
    tick();
    ill_i = csr_i(12'hC00, 5'd1, 3'b001, 5'd4);
    issue(ill_i, 32'h5);
    check("ro_write_illegal", illegal_csr, 1);
    check("ro_write_rd_en", rd_enable, 0);
    tick();
    check("ill_flush_addr", flush_addr, 32'h100);
    issue(NOP);
    tick();
    issue(csr_i(12'h342, 5'd0, 3'b010, 5'd1));
    check("ill_mcause", rd_data, 32'h2);
    tick();
    issue(csr_i(12'h343, 5'd0, 3'b010, 5'd1));
    check("ill_mtval", rd_data, ill_i);
    tick();
    issue(csr_i(12'hC00, 5'd0, 3'b010, 5'd5));
    check("ro_read_legal", illegal_csr, 0);
    check("ro_read_rd_en", rd_enable, 1);
    tick();
    issue(csr_i(12'h340, 5'd0, 3'b100, 5'd1));
    check("f3_100_illegal", illegal_csr, 1);
    tick();
    issue(NOP);
    tick();
    issue(csr_i(12'hB00, 5'd1, 3'b001, 5'd0), 32'hFFFF_FFFF);
    tick();
    issue(csr_i(12'hB80, 5'd1, 3'b001, 5'd0), 32'h0);
    tick();
    issue(csr_i(12'hB00, 5'd0, 3'b010, 5'd1));
    check("mcycle_preinc", rd_data, 32'hFFFF_FFFF);
    tick();
    issue(csr_i(12'hB00, 5'd0, 3'b010, 5'd1));
    check("mcycle_wrapped", rd_data, 32'h0);
    tick();
    issue(csr_i(12'hB80, 5'd0, 3'b010, 5'd1));
    check("mcycleh_carry", rd_data, 32'h1);
    tick();
    issue(csr_i(12'hB02, 5'd1, 3'b001, 5'd0), 32'h1234, 0, 0, 0, 0, 1);
    tick();
    issue(csr_i(12'hB02, 5'd0, 3'b010, 5'd1));
    check("minstret_write_wins", rd_data, 32'h1234);
    tick();
    issue(NOP, 0, 1, 4'd3, 0, 32'h10);
    tick();
    check("pre_rst_flush", flush, 1);
    do_reset();
    issue(csr_i(12'h305, 5'd0, 3'b010, 5'd1));
    check("mtvec_after_rst", rd_data, RV);
    tick();
    for (int k = 0; k < 3000; k++) begin
      a = addrs[$urandom_range(0, 19)];
      ins = {a, ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom), 3'($urandom), 5'($urandom), 7'h73};
      if ($urandom_range(0, 15) == 0) ins = MRET;
      if ($urandom_range(0, 15) == 0) ins = NOP;
      if ($urandom_range(0, 299) == 0) do_reset();
      else begin
        issue(ins, $urandom, $urandom_range(0, 9) == 0, 4'($urandom), $urandom, $urandom,
              1'($urandom), $urandom_range(0, 9) != 0);
        tick();
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
